// File: rtl/count_pkg.sv
// count_pkg: shared opcode constants and FSM state encoding for count_sequencer
package count_pkg;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/up_down_step_counter.sv
// up_down_step_counter: loadable mod-2^WIDTH up/down counter; in clock,clear,load,load_value,step,up; out count,wrap (registered pulse after a wrapping step)
module up_down_step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  always_ff @(posedge clock)
    if (clear) begin
      count <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= !load && step && (up ? &count : ~|count);
      count <= load ? load_value : step ? (up ? count + 1'b1 : count - 1'b1) : count;
    end
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: command FSM (LOAD/UP/DOWN/HOLD) over a step counter; in clock,clear,cmd_valid,cmd_op,cmd_data,abort; out cmd_ready,count,busy,done,wrap
module count_sequencer
  import count_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  state_t state;
  logic [WIDTH-1:0] remaining;
  logic up;
  logic accept;
  logic step;
  assign cmd_ready = state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign step = state == RUN && !abort;
  up_down_step_counter #(.WIDTH(WIDTH)) u_ctr (
    .clock(clock),
    .clear(clear),
    .load(accept && cmd_op == OP_LOAD),
    .load_value(cmd_data),
    .step(step),
    .up(up),
    .count(count),
    .wrap(wrap)
  );
  always_ff @(posedge clock)
    if (clear) begin
      state <= IDLE;
      remaining <= '0;
      up <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else
      case (state)
        IDLE:
          if (cmd_valid) begin
            busy <= 1'b1;
            if ((cmd_op == OP_UP || cmd_op == OP_DOWN) && cmd_data != '0) begin
              state <= RUN;
              remaining <= cmd_data;
              up <= cmd_op == OP_UP;
            end else begin
              state <= DONE;
              done <= 1'b1;
            end
          end
        RUN: begin
          if (!abort) remaining <= remaining - 1'b1;
          if (abort || remaining == WIDTH'(1)) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed self-checking bench for count_sequencer
module tb_count_sequencer;
  logic clock = 1'b0;
  logic clear = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'd0;
  logic abort = 1'b0;
  logic [3:0] count;
  logic busy;
  logic done;
  logic wrap;
  int tests = 0;
  int fails = 0;
  count_sequencer #(.WIDTH(4)) dut (
    .clock(clock),
    .clear(clear),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .abort(abort),
    .count(count),
    .busy(busy),
    .done(done),
    .wrap(wrap)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    tick();
    cmd_valid = 1'b0;
  endtask
  int exp_cnt[12] = '{3, 3, 3, 4, 5, 5, 5, 5, 5, 4, 4, 4};
  int exp_done[12] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0};
  int exp_rdy[12] = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1};
  initial begin
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    check("rst_ready", cmd_ready, 1);
    clear = 1'b0;
    send(2'b00, 4'd5);
    check("load5_count", count, 5);
    check("load5_done", done, 1);
    check("load5_busy", busy, 1);
    check("load5_ready", cmd_ready, 0);
    check("load5_wrap", wrap, 0);
    tick();
    check("load5_done_off", done, 0);
    check("load5_ready_back", cmd_ready, 1);
    check("load5_hold", count, 5);
    send(2'b00, 4'd14);
    tick();
    send(2'b01, 4'd3);
    check("up3_acc_count", count, 14);
    check("up3_acc_done", done, 0);
    tick();
    check("up3_s1_count", count, 15);
    check("up3_s1_wrap", wrap, 0);
    tick();
    check("up3_s2_count", count, 0);
    check("up3_s2_wrap", wrap, 1);
    check("up3_s2_done", done, 0);
    tick();
    check("up3_s3_count", count, 1);
    check("up3_s3_wrap", wrap, 0);
    check("up3_s3_done", done, 1);
    tick();
    check("up3_end_done", done, 0);
    check("up3_end_ready", cmd_ready, 1);
    send(2'b00, 4'd1);
    tick();
    send(2'b10, 4'd2);
    tick();
    check("dn2_s1_count", count, 0);
    check("dn2_s1_wrap", wrap, 0);
    tick();
    check("dn2_s2_count", count, 15);
    check("dn2_s2_wrap", wrap, 1);
    check("dn2_s2_done", done, 1);
    tick();
    check("dn2_end_wrap", wrap, 0);
    check("dn2_end_ready", cmd_ready, 1);
    send(2'b01, 4'd0);
    check("up0_done", done, 1);
    check("up0_count", count, 15);
    tick();
    check("up0_ready", cmd_ready, 1);
    check("up0_hold", count, 15);
    send(2'b00, 4'd0);
    tick();
    send(2'b01, 4'd10);
    tick();
    tick();
    tick();
    check("abort_pre_count", count, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_count", count, 3);
    check("abort_done", done, 1);
    tick();
    check("abort_after_count", count, 3);
    check("abort_after_ready", cmd_ready, 1);
    tick();
    check("abort_still_count", count, 3);
    send(2'b01, 4'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_last_count", count, 3);
    check("abort_last_done", done, 1);
    tick();
    abort = 1'b1;
    send(2'b00, 4'd7);
    abort = 1'b0;
    check("abort_idle_count", count, 7);
    check("abort_idle_done", done, 1);
    tick();
    send(2'b01, 4'd10);
    tick();
    tick();
    check("clr_pre_count", count, 9);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_data = 4'd2;
    clear = 1'b1;
    tick();
    check("clr_count", count, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_wrap", wrap, 0);
    clear = 1'b0;
    cmd_valid = 1'b0;
    check("clr_ready", cmd_ready, 1);
    tick();
    check("clr_noacc_count", count, 0);
    check("clr_noacc_done", done, 0);
    check("clr_noacc_busy", busy, 0);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_data = 4'd3;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("stream%0d_count", i), count, 8'(exp_cnt[i]));
      check($sformatf("stream%0d_done", i), done, 8'(exp_done[i]));
      check($sformatf("stream%0d_ready", i), cmd_ready, 8'(exp_rdy[i]));
      case (i)
        0: begin cmd_op = 2'b01; cmd_data = 4'd2; end
        2: begin cmd_op = 2'b11; cmd_data = 4'd9; end
        6: begin cmd_op = 2'b10; cmd_data = 4'd1; end
        8: cmd_valid = 1'b0;
        default: ;
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
